// File: rtl/mem_stage_if.sv
// Data-memory request port between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues load/store requests to data memory, stalls the front of the
// pipeline while an access is outstanding, and holds the MEM/WB register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        mem_MemWr_in,
    input  logic        mem_MemRead_in,
    input  logic [1:0]  mem_MemToReg_in,
    input  logic        mem_RegWrite_in,
    input  logic [4:0]  mem_RegWriteAddr_in,
    input  logic [31:0] mem_ALUOut_in,
    input  logic [31:0] mem_DataBus2_in,
    input  logic [31:0] mem_pc_plus_4_in,

    mem_stage_if.master dmem,

    output logic        mem_stall,

    output logic        mem_wb_RegWrite_out,
    output logic [1:0]  mem_wb_MemToReg_out,
    output logic [4:0]  mem_wb_RegWriteAddr_out,
    output logic [31:0] mem_wb_RegWriteData_out,

    output logic        mem_fault,
    output logic [31:0] mem_fault_addr
);

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wb_rw_q, wb_rw_d;
    logic [1:0]  wb_m2r_q, wb_m2r_d;
    logic [4:0]  wb_ra_q, wb_ra_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic        access;
    logic        misaligned;
    logic        stall_raw;
    logic        wb_load;
    logic        wb_bubble;
    logic [31:0] alu_sel_data;

    assign access       = mem_MemWr_in | mem_MemRead_in;
    assign misaligned   = (mem_ALUOut_in[1:0] != 2'b00);
    // Select 01 only returns load data when it comes from a completed access.
    assign alu_sel_data = (mem_MemToReg_in == 2'b10) ? mem_pc_plus_4_in : mem_ALUOut_in;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        stall_raw    = 1'b0;
        wb_load      = 1'b0;
        wb_bubble    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!access) begin
                    wb_load = 1'b1;
                end else if (misaligned) begin
                    fault_d      = 1'b1;
                    fault_addr_d = mem_ALUOut_in;
                    wb_bubble    = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                    state_d   = StBusy;
                    req_d     = 1'b1;
                    we_d      = mem_MemWr_in;
                    addr_d    = mem_ALUOut_in;
                    wdata_d   = mem_DataBus2_in;
                    cnt_d     = 8'd0;
                end
            end
            StBusy: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                    wb_load = 1'b1;
                end else if (cnt_q == TimeoutLast) begin
                    req_d        = 1'b0;
                    state_d      = StIdle;
                    fault_d      = 1'b1;
                    fault_addr_d = addr_q;
                    wb_bubble    = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // MEM/WB holds during a stall so a repeated write-back stays idempotent.
    always_comb begin
        wb_rw_d   = wb_rw_q;
        wb_m2r_d  = wb_m2r_q;
        wb_ra_d   = wb_ra_q;
        wb_data_d = wb_data_q;
        if (wb_bubble) begin
            wb_rw_d   = 1'b0;
            wb_m2r_d  = 2'b00;
            wb_ra_d   = 5'd0;
            wb_data_d = 32'd0;
        end else if (wb_load) begin
            wb_rw_d  = mem_RegWrite_in;
            wb_m2r_d = mem_MemToReg_in;
            wb_ra_d  = mem_RegWriteAddr_in;
            if (state_q == StBusy && mem_MemToReg_in == 2'b01) begin
                wb_data_d = dmem.dmem_rdata;
            end else begin
                wb_data_d = alu_sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wb_rw_q      <= 1'b0;
            wb_m2r_q     <= 2'b00;
            wb_ra_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wb_rw_q      <= wb_rw_d;
            wb_m2r_q     <= wb_m2r_d;
            wb_ra_q      <= wb_ra_d;
            wb_data_q    <= wb_data_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign mem_stall = rst_n & stall_raw;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign mem_wb_RegWrite_out     = wb_rw_q;
    assign mem_wb_MemToReg_out     = wb_m2r_q;
    assign mem_wb_RegWriteAddr_out = wb_ra_q;
    assign mem_wb_RegWriteData_out = wb_data_q;

    assign mem_fault      = fault_q;
    assign mem_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues directed ops and queues expectations,
// independent monitors compare MEM/WB, memory requests and fault pulses.
module tb_mem_stage;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [1:0]  m2r;
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] alu;
        logic [31:0] d2;
        logic [31:0] pc4;
    } op_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  m2r;
        logic [4:0]  ra;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mem_MemWr_in, mem_MemRead_in, mem_RegWrite_in;
    logic [1:0]  mem_MemToReg_in;
    logic [4:0]  mem_RegWriteAddr_in;
    logic [31:0] mem_ALUOut_in, mem_DataBus2_in, mem_pc_plus_4_in;
    logic        mem_stall, mem_fault;
    logic        mem_wb_RegWrite_out;
    logic [1:0]  mem_wb_MemToReg_out;
    logic [4:0]  mem_wb_RegWriteAddr_out;
    logic [31:0] mem_wb_RegWriteData_out, mem_fault_addr;

    mem_stage_if mif();

    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] resp_rdata = 32'd0;
    int          resp_dly = -1;
    int          resp_age = 0;

    assign mif.dmem_ack   = resp_ack | stray_ack;
    assign mif.dmem_rdata = resp_ack ? resp_rdata : 32'h5555_5555;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mem_MemWr_in            (mem_MemWr_in),
        .mem_MemRead_in          (mem_MemRead_in),
        .mem_MemToReg_in         (mem_MemToReg_in),
        .mem_RegWrite_in         (mem_RegWrite_in),
        .mem_RegWriteAddr_in     (mem_RegWriteAddr_in),
        .mem_ALUOut_in           (mem_ALUOut_in),
        .mem_DataBus2_in         (mem_DataBus2_in),
        .mem_pc_plus_4_in        (mem_pc_plus_4_in),
        .dmem                    (mif),
        .mem_stall               (mem_stall),
        .mem_wb_RegWrite_out     (mem_wb_RegWrite_out),
        .mem_wb_MemToReg_out     (mem_wb_MemToReg_out),
        .mem_wb_RegWriteAddr_out (mem_wb_RegWriteAddr_out),
        .mem_wb_RegWriteData_out (mem_wb_RegWriteData_out),
        .mem_fault               (mem_fault),
        .mem_fault_addr          (mem_fault_addr)
    );

    int total = 0;
    int bad = 0;

    wb_t         wb_q[$];
    rq_t         rq_q[$];
    logic [31:0] flt_q[$];

    wb_t  last_exp = '0;
    bit   running = 1'b0;
    bit   reset_pend = 1'b0;
    logic req_prev = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wb_t wb_act();
        wb_t w;
        w.rw   = mem_wb_RegWrite_out;
        w.m2r  = mem_wb_MemToReg_out;
        w.ra   = mem_wb_RegWriteAddr_out;
        w.data = mem_wb_RegWriteData_out;
        return w;
    endfunction

    function automatic op_t mk_op(input logic wr, input logic rd, input logic [1:0] m2r,
                                  input logic rw, input logic [4:0] ra, input logic [31:0] alu,
                                  input logic [31:0] d2, input logic [31:0] pc4);
        op_t o;
        o.wr = wr; o.rd = rd; o.m2r = m2r; o.rw = rw; o.ra = ra;
        o.alu = alu; o.d2 = d2; o.pc4 = pc4;
        return o;
    endfunction

    function automatic wb_t mk_wb(input logic rw, input logic [1:0] m2r, input logic [4:0] ra,
                                  input logic [31:0] data);
        wb_t w;
        w.rw = rw; w.m2r = m2r; w.ra = ra; w.data = data;
        return w;
    endfunction

    task automatic apply(input op_t o);
        mem_MemWr_in        = o.wr;
        mem_MemRead_in      = o.rd;
        mem_MemToReg_in     = o.m2r;
        mem_RegWrite_in     = o.rw;
        mem_RegWriteAddr_in = o.ra;
        mem_ALUOut_in       = o.alu;
        mem_DataBus2_in     = o.d2;
        mem_pc_plus_4_in    = o.pc4;
    endtask

    task automatic push_req(input op_t o);
        rq_t r;
        r.we = o.wr; r.addr = o.alu; r.wdata = o.d2;
        rq_q.push_back(r);
    endtask

    // Entered just after a rising edge; returns just after the edge that retires the op.
    task automatic issue(input string name, input op_t o, input int dly, input logic [31:0] rdata,
                         input int exp_stall, input int exp_req, input wb_t exp_wb,
                         input bit exp_fault);
        int stalls = 0;
        int reqs = 0;
        bit done = 1'b0;
        apply(o);
        resp_dly   = dly;
        resp_rdata = rdata;
        wb_q.push_back(exp_wb);
        if ((o.wr | o.rd) && o.alu[1:0] == 2'b00) push_req(o);
        if (exp_fault) flt_q.push_back(o.alu);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (mif.dmem_req) reqs++;
            if (mem_stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        check({name, "_done"}, 96'(done), 96'd1);
        check({name, "_stall_cycles"}, 96'(stalls), 96'(exp_stall));
        check({name, "_req_cycles"}, 96'(reqs), 96'(exp_req));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"}, 96'(mem_stall), 96'd0);
        check({tag, "_req_we"}, 96'({mif.dmem_req, mif.dmem_we}), 96'd0);
        check({tag, "_addr_wdata"}, 96'({mif.dmem_addr, mif.dmem_wdata}), 96'd0);
        check({tag, "_wb"}, 96'(wb_act()), 96'd0);
        check({tag, "_fault"}, 96'({mem_fault, mem_fault_addr}), 96'd0);
    endtask

    // Memory model: ack resp_dly cycles after the request rises (-1 never acks).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                resp_age = 0;
            end else if (mif.dmem_req) begin
                if (resp_age == resp_dly) resp_ack = 1'b1;
                resp_age++;
            end else begin
                resp_age = 0;
            end
        end
    end

    initial begin : wb_monitor
        forever begin
            @(negedge clk);
            if (!running) continue;
            if (!rst_n) begin
                reset_pend = 1'b1;
                continue;
            end
            if (reset_pend) begin
                last_exp   = '0;
                reset_pend = 1'b0;
            end
            if (mem_stall) begin
                check("wb_hold", 96'(wb_act()), 96'(last_exp));
            end else begin
                @(posedge clk);
                #1;
                if (wb_q.size() == 0) begin
                    check("wb_unexpected_load", 96'(wb_act()), 96'(last_exp));
                end else begin
                    last_exp = wb_q.pop_front();
                    check("wb_load", 96'(wb_act()), 96'(last_exp));
                end
            end
        end
    end

    initial begin : req_monitor
        forever begin
            @(negedge clk);
            if (mif.dmem_req && !req_prev) begin
                total++;
                if (rq_q.size() == 0) begin
                    bad++;
                    $display("FAIL req_unexpected: got addr %0h expected no request",
                             mif.dmem_addr);
                end else begin
                    rq_t r;
                    total--;
                    r = rq_q.pop_front();
                    check("req_fields", 96'({mif.dmem_we, mif.dmem_addr, mif.dmem_wdata}),
                          96'(r));
                end
            end
            req_prev = mif.dmem_req;
        end
    end

    initial begin : fault_monitor
        forever begin
            @(negedge clk);
            if (mem_fault) begin
                if (flt_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fault_unexpected: got addr %0h expected no fault",
                             mem_fault_addr);
                end else begin
                    check("fault_addr", 96'(mem_fault_addr), 96'(flt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        op_t ld;
        apply(mk_op(1'b0, 1'b1, 2'b01, 1'b1, 5'd3, 32'h100, 32'h0, 32'h4));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        running = 1'b1;

        issue("alu", mk_op(1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h4),
              -1, 32'h0, 0, 0, mk_wb(1'b1, 2'b00, 5'd5, 32'h1234), 1'b0);
        issue("sel_pc4", mk_op(1'b0, 1'b0, 2'b10, 1'b1, 5'd31, 32'h55, 32'h0, 32'h20),
              -1, 32'h0, 0, 0, mk_wb(1'b1, 2'b10, 5'd31, 32'h20), 1'b0);
        issue("sel_11", mk_op(1'b0, 1'b0, 2'b11, 1'b1, 5'd7, 32'hABCD, 32'h0, 32'h99),
              -1, 32'h0, 0, 0, mk_wb(1'b1, 2'b11, 5'd7, 32'hABCD), 1'b0);
        issue("sel_01_noacc", mk_op(1'b0, 1'b0, 2'b01, 1'b1, 5'd1, 32'h77, 32'h0, 32'h8),
              -1, 32'h0, 0, 0, mk_wb(1'b1, 2'b01, 5'd1, 32'h77), 1'b0);
        // Ack arrives in the same cycle the timeout counter expires.
        issue("load_ack3", mk_op(1'b0, 1'b1, 2'b01, 1'b1, 5'd3, 32'h100, 32'h1111, 32'h4),
              3, 32'hDEADBEEF, 4, 4, mk_wb(1'b1, 2'b01, 5'd3, 32'hDEADBEEF), 1'b0);
        issue("store_ack0", mk_op(1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h40, 32'hCAFE, 32'h4),
              0, 32'hFFFF0000, 1, 1, mk_wb(1'b0, 2'b00, 5'd0, 32'h40), 1'b0);
        issue("wr_rd_both", mk_op(1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h80, 32'h5A5A, 32'h4),
              1, 32'h13, 2, 2, mk_wb(1'b0, 2'b00, 5'd0, 32'h80), 1'b0);
        issue("load_misalign", mk_op(1'b0, 1'b1, 2'b01, 1'b1, 5'd4, 32'h102, 32'h0, 32'h4),
              -1, 32'h0, 0, 0, mk_wb(1'b0, 2'b00, 5'd0, 32'h0), 1'b1);
        issue("store_misalign", mk_op(1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h41, 32'h9, 32'h4),
              -1, 32'h0, 0, 0, mk_wb(1'b0, 2'b00, 5'd0, 32'h0), 1'b1);
        issue("load_timeout", mk_op(1'b0, 1'b1, 2'b01, 1'b1, 5'd6, 32'h200, 32'h0, 32'h4),
              -1, 32'h0, 4, 4, mk_wb(1'b0, 2'b00, 5'd0, 32'h0), 1'b1);
        stray_ack = 1'b1;
        issue("idle_stray_ack", mk_op(1'b0, 1'b0, 2'b00, 1'b1, 5'd2, 32'h3, 32'h0, 32'h4),
              -1, 32'h0, 0, 0, mk_wb(1'b1, 2'b00, 5'd2, 32'h3), 1'b0);
        stray_ack = 1'b0;
        issue("load_ack2", mk_op(1'b0, 1'b1, 2'b01, 1'b1, 5'd8, 32'h300, 32'h0, 32'h4),
              2, 32'h0BADF00D, 3, 3, mk_wb(1'b1, 2'b01, 5'd8, 32'h0BADF00D), 1'b0);

        // Reset lands in the second BUSY cycle of a load that is never acked.
        ld = mk_op(1'b0, 1'b1, 2'b01, 1'b1, 5'd10, 32'h400, 32'h77, 32'h4);
        apply(ld);
        resp_dly = -1;
        push_req(ld);
        @(negedge clk);
        check("rst_seq_idle_stall", 96'(mem_stall), 96'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_seq_busy_req", 96'(mif.dmem_req), 96'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_seq_stall_in_reset", 96'(mem_stall), 96'd0);
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        rst_n = 1'b1;
        issue("jal_after_reset", mk_op(1'b0, 1'b0, 2'b10, 1'b1, 5'd31, 32'h1000, 32'h0, 32'hC),
              -1, 32'h0, 0, 0, mk_wb(1'b1, 2'b10, 5'd31, 32'hC), 1'b0);

        running = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("wb_queue_drained", 96'(wb_q.size()), 96'd0);
        check("req_queue_drained", 96'(rq_q.size()), 96'd0);
        check("fault_queue_drained", 96'(flt_q.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
